apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the AHB-to-APB bridge.
//  Requester 0 is the CPU side; requester 1 is the debug/DMA side.
//  Serialises their single-beat transfers onto the bridge select/address/data inputs.
//  Tracks bridge hready to complete each transfer; returns read data, ack and error.
// PARAMETERS
//  ADDR_W   40  transfer address width
//  DATA_W   32  read/write data width
//  TO_CYC   16  max WAIT cycles before timeout (legal range 4..255)
// PORTS
//  hclk              in   1       clock, rising edge
//  hrst              in   1       asynchronous reset, active-high
//  m0_req/m1_req     in   1       transfer request, held until ack
//  m0_addr/m1_addr   in   ADDR_W  address, stable while req=1
//  m0_write/m1_write in   1       1=write, 0=read, stable while req=1
//  m0_wdata/m1_wdata in   DATA_W  write data, stable while req=1
//  m0_ack/m1_ack     out  1       one-cycle completion pulse
//  m0_rdata/m1_rdata out  DATA_W  read data, valid with ack, held until next ack
//  m0_err/m1_err     out  1       timeout flag, valid with ack
//  harb_apb_hsel     out  1       bridge select, high one cycle per transfer
//  harb_xx_haddr     out  ADDR_W  bridge address
//  harb_xx_hwrite    out  1       bridge direction
//  harb_xx_hwdata    out  DATA_W  bridge write data
//  apb_harb_hready   in   1       bridge ready (registered in bridge)
//  apb_harb_hrdata   in   DATA_W  bridge read data, valid when hready=1 in WAIT
//  arb_gnt           out  2       one-hot owner of current transfer, 0 when IDLE
//  arb_busy          out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0.
//   - State is IDLE.
//   - Round-robin pointer last=1, so m0 wins the first tie.
//   - Timeout counter is 0.
//  FSM states: IDLE, ADDR, WAIT, RESP. All outputs are registered.
//  IDLE:
//   - Grants only if (m0_req | m1_req) and apb_harb_hready=1.
//   - A single request wins.
//   - On a tie, the requester not equal to last wins; last updates to the winner.
//   - On grant: latch winner addr/write/wdata into harb_xx_*, set arb_gnt, go to ADDR.
//  ADDR (exactly 1 cycle):
//   - harb_apb_hsel=1; hready is not examined.
//   - Go to WAIT with counter cleared.
//  WAIT:
//   - hsel=0; harb_xx_* held (bridge captures hwdata one cycle after select).
//   - If hready=1: capture hrdata (reads only) into the owner's rdata, err=0, go to RESP.
//   - Else if counter==TO_CYC-1: owner rdata=0, err=1, go to RESP.
//   - Otherwise counter+1 (saturating width ceil(log2(TO_CYC))).
//  RESP (1 cycle):
//   - Owner ack=1; other requester's ack=0.
//   - Then IDLE with arb_gnt=0; harb_xx_* keep their last values.
//  Ack and rdata rules:
//   - Requester must drop req at the edge that ends its ack cycle.
//   - A req still high in IDLE is treated as a new transfer.
//   - Writes leave the owner's rdata unchanged.
//   - Non-owner rdata/err are never modified.
//  Latency from req sampled in IDLE to ack, with the bridge responding normally:
//   - Read: 4 cycles (ADDR, WAIT x2, RESP).
//   - Write: 5 cycles (ADDR, WAIT x3, RESP).
//   - Minimum spacing between hsel pulses: 5 cycles read, 6 cycles write.
//  Requests arriving while busy wait in IDLE arbitration. No starvation: alternates under contention.
//  After a timeout, IDLE does not grant until hready=1, so the bridge is never selected mid-transfer.
//  Reset asserted mid-transfer:
//   - Immediate return to reset values.
//   - No ack is issued for the aborted transfer.
// TESTING
//  1. Single read: m0_req, addr 40'h10015004, bridge returns 32'hA5A5_0001
//     -> hsel pulses 1 cycle after req; m0_ack 4 cycles after req; m0_rdata=32'hA5A5_0001, m0_err=0.
//  2. Single write: m1 write 32'hDEAD_BEEF to 40'h10011000
//     -> haddr/hwdata held from ADDR through RESP; m1_ack 5 cycles after req; m1_rdata unchanged.
//  3. Contention: m0_req and m1_req high together, each reissuing after ack for 4 transfers
//     -> grant order m0,m1,m0,m1; arb_gnt one-hot during each transfer.
//  4. Timeout: hold hready=0 after hsel, TO_CYC=16
//     -> ack with err=1 and rdata=0 after 16 WAIT cycles; no new hsel until hready=1.
//  5. Reset mid-WAIT: assert hrst during WAIT of a read
//     -> all outputs 0 asynchronously; no ack; first post-reset tie granted to m0.
//  6. Back-to-back reads on m0 (req re-raised the cycle after ack)
//     -> hsel pulses exactly 5 cycles apart; rdata updates on each ack.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Requester-side handshake bundle for the two-port APB request arbiter.
// The requester drives req/addr/write/wdata; the arbiter returns ack/rdata/err.
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, addr, write, wdata, input  ack, rdata, err);
    modport slave  (input  req, addr, write, wdata, output ack, rdata, err);
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin sequencer in front of the AHB-to-APB bridge.
// One single-beat transfer at a time: IDLE -> ADDR -> WAIT -> RESP -> IDLE.
// Every output comes straight from a flop.
module apb_req_arbiter #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 16
) (
    input  logic              hclk,
    input  logic              hrst,
    apb_req_arbiter_if.slave  m0,
    apb_req_arbiter_if.slave  m1,
    output logic              harb_apb_hsel,
    output logic [ADDR_W-1:0] harb_xx_haddr,
    output logic              harb_xx_hwrite,
    output logic [DATA_W-1:0] harb_xx_hwdata,
    input  logic              apb_harb_hready,
    input  logic [DATA_W-1:0] apb_harb_hrdata,
    output logic [1:0]        arb_gnt,
    output logic              arb_busy
);

    localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;

    state_t                   state_q,  state_d;
    logic                     last_q,   last_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic                     hsel_q,   hsel_d;
    logic [ADDR_W-1:0]        haddr_q,  haddr_d;
    logic                     hwrite_q, hwrite_d;
    logic [DATA_W-1:0]        hwdata_q, hwdata_d;
    logic [1:0]               gnt_q,    gnt_d;
    logic                     busy_q,   busy_d;
    logic [1:0]               ack_q,    ack_d;
    logic [1:0][DATA_W-1:0]   rdata_q,  rdata_d;
    logic [1:0]               err_q,    err_d;

    logic pick;   // arbitration winner in IDLE (0 = m0, 1 = m1)
    logic owner;  // requester that owns the transfer in flight

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        hsel_d   = 1'b0;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        ack_d    = 2'b00;
        rdata_d  = rdata_q;
        err_d    = err_q;
        owner    = gnt_q[1];
        pick     = (m0.req && m1.req) ? ~last_q : m1.req;

        case (state_q)
            S_IDLE: begin
                // hready low here means the bridge is still busy with a
                // transfer we abandoned on timeout: never select it mid-flight.
                if ((m0.req || m1.req) && apb_harb_hready) begin
                    last_d   = pick;
                    haddr_d  = pick ? m1.addr  : m0.addr;
                    hwrite_d = pick ? m1.write : m0.write;
                    hwdata_d = pick ? m1.wdata : m0.wdata;
                    gnt_d    = pick ? 2'b10 : 2'b01;
                    busy_d   = 1'b1;
                    hsel_d   = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (apb_harb_hready) begin
                    if (!hwrite_q) rdata_d[owner] = apb_harb_hrdata;
                    err_d[owner] = 1'b0;
                    ack_d[owner] = 1'b1;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d[owner] = '0;
                    err_d[owner]   = 1'b1;
                    ack_d[owner]   = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                // Bridge-side address/data stay put; only ownership drops.
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset leaves m0 winning the first tie.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            gnt_q    <= 2'b00;
            busy_q   <= 1'b0;
            ack_q    <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            hsel_q   <= hsel_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign m0.ack   = ack_q[0];
    assign m0.rdata = rdata_q[0];
    assign m0.err   = err_q[0];
    assign m1.ack   = ack_q[1];
    assign m1.rdata = rdata_q[1];
    assign m1.err   = err_q[1];

    assign harb_apb_hsel  = hsel_q;
    assign harb_xx_haddr  = haddr_q;
    assign harb_xx_hwrite = hwrite_q;
    assign harb_xx_hwdata = hwdata_q;
    assign arb_gnt        = gnt_q;
    assign arb_busy       = busy_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: requester tasks push expected
// responses, a negedge monitor pops them on ack and also checks grant
// order, bridge-side fields and busy/gnt against a rule-level model.
module tb_apb_req_arbiter;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 32;
    localparam int TO_CYC = 16;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
    } exp_t;

    logic hclk = 1'b0;
    logic hrst = 1'b1;
    always #5 hclk = ~hclk;

    logic [1:0]             req_t   = '0;
    logic [1:0]             wr_t    = '0;
    logic [1:0][ADDR_W-1:0] addr_t  = '0;
    logic [1:0][DATA_W-1:0] wdata_t = '0;
    logic [1:0]             ack_w, err_w;
    logic [1:0][DATA_W-1:0] rd_w;

    logic              hsel, hwrite, hready, busy;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata, hrdata;
    logic [1:0]        gnt;
    logic              stall = 1'b0;
    int                rem;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_m = 1;
    exp_t q0[$];
    exp_t q1[$];
    int grant_log[$];
    int hsel_times[$];
    logic [DATA_W-1:0] exp_last [2];
    logic [DATA_W-1:0] hold [2];

    apb_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    apb_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    assign m0_if.req   = req_t[0];
    assign m0_if.addr  = addr_t[0];
    assign m0_if.write = wr_t[0];
    assign m0_if.wdata = wdata_t[0];
    assign m1_if.req   = req_t[1];
    assign m1_if.addr  = addr_t[1];
    assign m1_if.write = wr_t[1];
    assign m1_if.wdata = wdata_t[1];
    assign ack_w = {m1_if.ack, m0_if.ack};
    assign err_w = {m1_if.err, m0_if.err};
    assign rd_w  = {m1_if.rdata, m0_if.rdata};

    apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
        .hclk            (hclk),
        .hrst            (hrst),
        .m0              (m0_if),
        .m1              (m1_if),
        .harb_apb_hsel   (hsel),
        .harb_xx_haddr   (haddr),
        .harb_xx_hwrite  (hwrite),
        .harb_xx_hwdata  (hwdata),
        .apb_harb_hready (hready),
        .apb_harb_hrdata (hrdata),
        .arb_gnt         (gnt),
        .arb_busy        (busy)
    );

    function automatic logic [DATA_W-1:0] rd_func(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'hB5A4_5005;
    endfunction

    // Bridge model: one setup + one wait cycle for reads, one more for writes.
    always @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            hready <= 1'b1;
            rem    <= 0;
            hrdata <= '0;
        end else if (stall) begin
            if (hsel) hready <= 1'b0;
            rem <= 0;
        end else if (hsel) begin
            hready <= 1'b0;
            rem    <= hwrite ? 2 : 1;
        end else if (rem == 2) begin
            rem <= 1;
        end else if (rem == 1) begin
            hready <= 1'b1;
            rem    <= 0;
            hrdata <= hwrite ? $urandom() : rd_func(haddr);
        end else begin
            hready <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hsel"},   hsel,   0);
        chk({tag, "_haddr"},  haddr,  0);
        chk({tag, "_hwrite"}, hwrite, 0);
        chk({tag, "_hwdata"}, hwdata, 0);
        chk({tag, "_gnt"},    gnt,    0);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_ack"},    ack_w,  0);
        chk({tag, "_err"},    err_w,  0);
        chk({tag, "_rdata"},  rd_w,   0);
    endtask

    // Requester: push expectation, hold req until ack, then drop or keep.
    task automatic xfer(input int m, input logic [ADDR_W-1:0] a, input logic w,
                        input logic [DATA_W-1:0] d, input logic to, input logic keep);
        exp_t e;
        int n;
        e.err   = to;
        e.rdata = to ? '0 : (w ? exp_last[m] : rd_func(a));
        e.lat   = to ? TO_CYC + 1 : (w ? 4 : 3);
        exp_last[m] = e.rdata;
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        req_t[m] = 1'b1; addr_t[m] = a; wr_t[m] = w; wdata_t[m] = d;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!ack_w[m] && n < 100);
        if (!ack_w[m]) begin
            total++; bad++;
            $display("FAIL ack_wait m%0d: got no ack after %0d cycles, want ack", m, n);
        end
        @(posedge hclk); #1;
        if (!keep) req_t[m] = 1'b0;
    endtask

    task automatic rand_master(input int m);
        logic [63:0] r;
        logic keep;
        int g;
        for (int i = 0; i < 30; i++) begin
            r = {$urandom(), $urandom()};
            keep = (i < 29) && ($urandom_range(0, 1) == 1);
            xfer(m, r[ADDR_W-1:0], $urandom_range(0, 1) == 1, $urandom(), 1'b0, keep);
            if (!keep) begin
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin @(posedge hclk); #1; end
            end
        end
    endtask

    // Monitor: scoreboard pops on ack plus rule-level grant/busy model.
    initial begin : mon
        logic p_idle, p_ack, p_hr, exp_hsel, cur_idle;
        logic [1:0] p_req;
        logic [ADDR_W-1:0] m_haddr;
        logic [DATA_W-1:0] m_hwdata;
        logic m_hwrite;
        int w, h_cyc, h_own;
        exp_t e;
        p_idle = 1'b1; p_ack = 1'b0; p_hr = 1'b1; p_req = 2'b00;
        m_haddr = '0; m_hwdata = '0; m_hwrite = 1'b0; h_cyc = 0; h_own = 0;
        hold[0] = '0; hold[1] = '0;
        forever begin
            @(negedge hclk);
            cyc++;
            if (hrst) begin
                p_idle = 1'b1; p_ack = 1'b0; p_hr = hready; p_req = 2'b00;
                m_haddr = '0; m_hwdata = '0; m_hwrite = 1'b0;
                last_m = 1; hold[0] = '0; hold[1] = '0;
                q0.delete(); q1.delete();
            end else begin
                exp_hsel = p_idle && (p_req != 2'b00) && p_hr;
                chk("hsel", hsel, exp_hsel);
                if (exp_hsel) begin
                    w = (p_req == 2'b11) ? (last_m == 0 ? 1 : 0) : (p_req[1] ? 1 : 0);
                    last_m = w; h_cyc = cyc; h_own = w;
                    grant_log.push_back(w);
                    hsel_times.push_back(cyc);
                    m_haddr = addr_t[w]; m_hwrite = wr_t[w]; m_hwdata = wdata_t[w];
                end
                cur_idle = p_ack || (p_idle && !exp_hsel);
                chk("busy", busy, !cur_idle);
                chk("gnt", gnt, cur_idle ? 2'b00 : (h_own == 1 ? 2'b10 : 2'b01));
                chk("haddr", haddr, m_haddr);
                chk("hwrite", hwrite, m_hwrite);
                chk("hwdata", hwdata, m_hwdata);
                for (int m = 0; m < 2; m++) begin
                    if (ack_w[m]) begin
                        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                            total++; bad++;
                            $display("FAIL ack_unexpected m%0d: got ack, want none", m);
                        end else begin
                            if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
                            chk($sformatf("rdata_m%0d", m), rd_w[m], e.rdata);
                            chk($sformatf("err_m%0d", m), err_w[m], e.err);
                            chk($sformatf("lat_m%0d", m), cyc - h_cyc, e.lat);
                            chk($sformatf("ack_owner_m%0d", m), h_own, m);
                            hold[m] = e.rdata;
                        end
                    end else begin
                        chk($sformatf("rdata_hold_m%0d", m), rd_w[m], hold[m]);
                    end
                end
                p_idle = cur_idle; p_ack = |ack_w; p_hr = hready; p_req = req_t;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int n0, n;
        logic [63:0] r;
        exp_last[0] = '0; exp_last[1] = '0;
        repeat (3) @(posedge hclk);
        #1;
        check_zero("por");
        hrst = 1'b0;
        repeat (2) begin @(posedge hclk); #1; end

        // 1: single read on m0
        xfer(0, 40'h10015004, 1'b0, '0, 1'b0, 1'b0);
        chk("t1_rdata", rd_w[0], 32'hA5A5_0001);
        chk("t1_err", err_w[0], 0);

        // 2: single write on m1
        xfer(1, 40'h10011000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t2_m1_rdata", rd_w[1], 0);
        chk("t2_haddr_kept", haddr, 40'h10011000);
        chk("t2_hwdata_kept", hwdata, 32'hDEAD_BEEF);

        // 3: contention, both reissue once
        n0 = grant_log.size();
        fork
            begin
                xfer(0, 40'h100, 1'b0, '0, 1'b0, 1'b1);
                xfer(0, 40'h104, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
            end
            begin
                xfer(1, 40'h200, 1'b1, 32'h3333_4444, 1'b0, 1'b1);
                xfer(1, 40'h204, 1'b0, '0, 1'b0, 1'b0);
            end
        join
        chk("t3_count", grant_log.size() - n0, 4);
        if (grant_log.size() >= n0 + 4)
            for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), grant_log[n0 + k], k % 2);

        // 4: timeout, then no select while bridge still busy
        stall = 1'b1;
        xfer(0, 40'h55_0000_0040, 1'b0, '0, 1'b1, 1'b0);
        chk("t4_rdata", rd_w[0], 0);
        chk("t4_err", err_w[0], 1);
        fork
            xfer(1, 40'h66_0000_0080, 1'b0, '0, 1'b0, 1'b0);
            begin
                repeat (6) begin @(negedge hclk); chk("t4_no_hsel", hsel, 0); end
                @(posedge hclk); #1;
                stall = 1'b0;
            end
        join
        chk("t4_m1_rdata", rd_w[1], rd_func(40'h66_0000_0080));

        // 6: back-to-back reads on m0
        n0 = hsel_times.size();
        for (int k = 0; k < 3; k++) begin
            xfer(0, 40'h10_0000_1000 + 40'(k * 4), 1'b0, '0, 1'b0, k < 2);
            chk($sformatf("t6_rdata%0d", k), rd_w[0], rd_func(40'h10_0000_1000 + 40'(k * 4)));
        end
        chk("t6_count", hsel_times.size() - n0, 3);
        if (hsel_times.size() >= n0 + 3) begin
            chk("t6_gap0", hsel_times[n0 + 1] - hsel_times[n0], 5);
            chk("t6_gap1", hsel_times[n0 + 2] - hsel_times[n0 + 1], 5);
        end

        // 5: reset during WAIT of an m0 read
        req_t[0] = 1'b1; addr_t[0] = 40'h77_0000_0010; wr_t[0] = 1'b0;
        n = 0;
        do begin @(negedge hclk); n++; end while (!hsel && n < 20);
        chk("t5_hsel_seen", hsel, 1);
        @(posedge hclk); #3;
        hrst = 1'b1;
        #1;
        check_zero("t5_async");
        req_t = 2'b00;
        exp_last[0] = '0; exp_last[1] = '0;
        repeat (2) @(posedge hclk);
        #1;
        hrst = 1'b0;
        @(posedge hclk); #1;
        n0 = grant_log.size();
        fork
            xfer(0, 40'h88_0000_0000, 1'b0, '0, 1'b0, 1'b0);
            xfer(1, 40'h99_0000_0000, 1'b0, '0, 1'b0, 1'b0);
        join
        chk("t5_count", grant_log.size() - n0, 2);
        if (grant_log.size() >= n0 + 2) begin
            chk("t5_first_m0", grant_log[n0], 0);
            chk("t5_then_m1", grant_log[n0 + 1], 1);
        end

        // randomized traffic on both requesters
        r = {$urandom(), $urandom()};
        fork
            rand_master(0);
            rand_master(1);
        join
        repeat (5) @(negedge hclk);
        chk("sb_empty", q0.size() + q1.size(), 0);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
